// File: rtl/dostring_pkg.sv
// Shared definitions for the dostring column sequencer, the doled serializer
// and the wave/colour generator: frame type codes, default geometry and the
// sequencer state encoding.
package dostring_pkg;

  typedef logic [1:0] input_type_t;

  localparam input_type_t INPUT_TYPE_START = 2'd0;
  localparam input_type_t INPUT_TYPE_LED   = 2'd1;
  localparam input_type_t INPUT_TYPE_END   = 2'd2;

  localparam int DEFAULT_STRING_SIZE    = 47;
  localparam int DEFAULT_NUMBER_STRINGS = 47;
  localparam int DEFAULT_COLUMN_PERIOD  = 50000;

  // One frame per state triple: *_GO waits for doled idle and pulses start,
  // *_HOLD covers the cycle before doled raises busy, *_WAIT waits busy out.
  typedef enum logic [3:0] {
    IDLE,
    START_GO,
    START_HOLD,
    START_WAIT,
    PIX_REQ,
    LED_GO,
    LED_HOLD,
    LED_WAIT,
    END_GO,
    END_HOLD,
    END_WAIT
  } seq_state_t;

  typedef struct packed {
    logic [7:0] blue;
    logic [7:0] green;
    logic [7:0] red;
  } rgb_t;

endpackage

// File: rtl/dostring_if.sv
// Pixel-fetch and doled frame buses seen by the sequencer. The master side is
// the sequencer; the slave side is the pixel generator plus doled.
interface dostring_if;
  import dostring_pkg::*;

  // Pixel generator request/valid handshake
  logic        pix_req;
  logic [7:0]  pix_led_index;
  logic [7:0]  pix_col_index;
  logic        pix_valid;
  logic [7:0]  pix_blue;
  logic [7:0]  pix_green;
  logic [7:0]  pix_red;

  // doled start/busy handshake
  logic        led_start;
  input_type_t led_type;
  logic [7:0]  led_blue;
  logic [7:0]  led_green;
  logic [7:0]  led_red;
  logic        led_busy;

  modport master (
    output pix_req, pix_led_index, pix_col_index,
    input  pix_valid, pix_blue, pix_green, pix_red,
    output led_start, led_type, led_blue, led_green, led_red,
    input  led_busy
  );

  modport slave (
    input  pix_req, pix_led_index, pix_col_index,
    output pix_valid, pix_blue, pix_green, pix_red,
    input  led_start, led_type, led_blue, led_green, led_red,
    output led_busy
  );

endinterface

// File: rtl/column_timer.sv
// Column period timer: counts 0..COLUMN_PERIOD-1 while enabled and flags the
// terminal count for one cycle. Held at zero while disabled.
module column_timer
  import dostring_pkg::*;
#(
  parameter int COLUMN_PERIOD = DEFAULT_COLUMN_PERIOD
) (
  input  logic dostring_clk,
  input  logic dostring_reset,
  input  logic enable,
  output logic tick
);

  localparam int            CW   = (COLUMN_PERIOD > 1) ? $clog2(COLUMN_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(COLUMN_PERIOD - 1);

  logic [CW-1:0] count;

  // Free-running period counter, wrapped by compare-and-clear
  always_ff @(posedge dostring_clk or posedge dostring_reset) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    if (dostring_reset) begin
      count <= '0;
    end else if (!enable) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/dostring_sequencer.sv
// Column scheduler: on each column tick sends START, STRING_SIZE LED frames
// and END to doled, fetching each LED colour from the pixel generator, then
// advances the column index modulo NUMBER_STRINGS.
module dostring_sequencer
  import dostring_pkg::*;
#(
  parameter int STRING_SIZE    = DEFAULT_STRING_SIZE,
  parameter int NUMBER_STRINGS = DEFAULT_NUMBER_STRINGS,
  parameter int COLUMN_PERIOD  = DEFAULT_COLUMN_PERIOD
) (
  input  logic              dostring_clk,
  input  logic              dostring_reset,
  input  logic              enable,
  dostring_if.master        bus,
  output logic [7:0]        col_index,
  output logic              frame_overrun
);

  localparam logic [7:0] LAST_LED = 8'(STRING_SIZE - 1);
  localparam logic [7:0] LAST_COL = 8'(NUMBER_STRINGS - 1);

  logic        tick;
  seq_state_t  state;
  seq_state_t  state_next;

  logic [7:0]  led_n;
  logic [7:0]  pix_col;
  input_type_t led_type_q;
  rgb_t        led_rgb;

  // Single-cycle strobes from the FSM to the datapath registers
  logic        start_pulse;
  logic        pixel_request;
  logic        load_column;
  logic        capture_pixel;
  logic        advance_led;
  logic        load_end;
  logic        advance_column;

  column_timer #(
    .COLUMN_PERIOD (COLUMN_PERIOD)
  ) u_column_timer (
    .dostring_clk   (dostring_clk),
    .dostring_reset (dostring_reset),
    .enable         (enable),
    .tick           (tick)
  );

  // State register; reset abandons any in-flight doled frame
  always_ff @(posedge dostring_clk or posedge dostring_reset) begin
    if (dostring_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and handshake strobes
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case can infer a latch.
    state_next     = state;
    start_pulse    = 1'b0;
    pixel_request  = 1'b0;
    load_column    = 1'b0;
    capture_pixel  = 1'b0;
    advance_led    = 1'b0;
    load_end       = 1'b0;
    advance_column = 1'b0;

    case (state)
      IDLE: begin
        if (tick) begin
          load_column = 1'b1;
          state_next  = START_GO;
        end
      end
      START_GO: begin
        if (!bus.led_busy) begin
          start_pulse = 1'b1;
          state_next  = START_HOLD;
        end
      end
      START_HOLD: state_next = START_WAIT;
      START_WAIT: begin
        if (!bus.led_busy) state_next = PIX_REQ;
      end
      PIX_REQ: begin
        pixel_request = 1'b1;
        if (bus.pix_valid) begin
          capture_pixel = 1'b1;
          state_next    = LED_GO;
        end
      end
      LED_GO: begin
        if (!bus.led_busy) begin
          start_pulse = 1'b1;
          state_next  = LED_HOLD;
        end
      end
      LED_HOLD: state_next = LED_WAIT;
      LED_WAIT: begin
        if (!bus.led_busy) begin
          if (led_n < LAST_LED) begin
            advance_led = 1'b1;
            state_next  = PIX_REQ;
          end else begin
            load_end   = 1'b1;
            state_next = END_GO;
          end
        end
      end
      END_GO: begin
        if (!bus.led_busy) begin
          start_pulse = 1'b1;
          state_next  = END_HOLD;
        end
      end
      END_HOLD: state_next = END_WAIT;
      END_WAIT: begin
        if (!bus.led_busy) begin
          advance_column = 1'b1;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame contents, LED counter and column index; frame registers change only
  // on entry to a *_GO state so they hold steady through the matching *_WAIT
  always_ff @(posedge dostring_clk or posedge dostring_reset) begin
    if (dostring_reset) begin
      led_n      <= '0;
      pix_col    <= '0;
      col_index  <= '0;
      led_type_q <= INPUT_TYPE_START;
      led_rgb    <= '0;
    end else begin
      if (load_column) begin
        pix_col    <= col_index;
        led_n      <= '0;
        led_type_q <= INPUT_TYPE_START;
        led_rgb    <= '0;
      end
      if (capture_pixel) begin
        led_type_q <= INPUT_TYPE_LED;
        led_rgb    <= '{blue: bus.pix_blue, green: bus.pix_green, red: bus.pix_red};
      end
      if (advance_led) begin
        led_n <= led_n + 8'd1;
      end
      if (load_end) begin
        led_type_q <= INPUT_TYPE_END;
        led_rgb    <= '0;
      end
      if (advance_column) begin
        col_index <= (col_index == LAST_COL) ? 8'd0 : col_index + 8'd1;
      end
    end
  end

  assign bus.led_start     = start_pulse;
  assign bus.led_type      = led_type_q;
  assign bus.led_blue      = led_rgb.blue;
  assign bus.led_green     = led_rgb.green;
  assign bus.led_red       = led_rgb.red;
  assign bus.pix_req       = pixel_request;
  assign bus.pix_led_index = led_n;
  assign bus.pix_col_index = pix_col;

  // A tick that finds a transfer still running is dropped and reported
  assign frame_overrun = tick && (state != IDLE);

endmodule

// File: tb/tb_dostring_sequencer.sv
// Bench for dostring_sequencer: a doled busy model, a pixel generator with
// programmable latency, and a transfer-level reference model that predicts
// the frame list, pixel requests, column sequence and dropped ticks.
module tb_dostring_sequencer;
  import dostring_pkg::*;

  localparam int SS = 4;
  localparam int NS = 3;
  localparam int CP = 200;

  logic       dostring_clk   = 1'b0;
  logic       dostring_reset = 1'b1;
  logic       enable         = 1'b0;
  logic [7:0] col_index;
  logic       frame_overrun;

  dostring_if bus ();

  dostring_sequencer #(
    .STRING_SIZE    (SS),
    .NUMBER_STRINGS (NS),
    .COLUMN_PERIOD  (CP)
  ) dut (
    .dostring_clk   (dostring_clk),
    .dostring_reset (dostring_reset),
    .enable         (enable),
    .bus            (bus),
    .col_index      (col_index),
    .frame_overrun  (frame_overrun)
  );

  always #5 dostring_clk = ~dostring_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [25:0] frame(input logic [1:0] t, input logic [7:0] b,
                                        input logic [7:0] g, input logic [7:0] r);
    return {t, b, g, r};
  endfunction

  // ---------------- doled model: busy for next_busy cycles after each start
  int busy_cnt  = 0;
  int next_busy = 10;
  always @(posedge dostring_clk or posedge dostring_reset) begin
    if (dostring_reset)     busy_cnt <= 0;
    else if (bus.led_start) busy_cnt <= next_busy;
    else if (busy_cnt > 0)  busy_cnt <= busy_cnt - 1;
  end
  assign bus.led_busy = (busy_cnt != 0);

  // ---------------- pixel generator: valid after lat_cur cycles of request
  int req_cnt      = 0;
  int lat_cur      = 0;
  int pix_lat_next = 0;
  always @(posedge dostring_clk or posedge dostring_reset) begin
    if (dostring_reset) req_cnt <= 0;
    else if (bus.pix_req && !bus.pix_valid) req_cnt <= req_cnt + 1;
    else req_cnt <= 0;
  end
  always @(posedge dostring_clk) begin
    if (!bus.pix_req) lat_cur <= pix_lat_next;
  end
  assign bus.pix_valid = bus.pix_req && (req_cnt >= lat_cur);
  assign bus.pix_blue  = bus.pix_led_index;
  assign bus.pix_green = bus.pix_col_index;
  assign bus.pix_red   = 8'h55;

  // ---------------- reference model state
  int en_run = 0;  // consecutive enabled clock edges
  always @(posedge dostring_clk or posedge dostring_reset) begin
    if (dostring_reset || !enable) en_run <= 0;
    else en_run <= en_run + 1;
  end

  int            cyc = 0;
  bit            active = 0;
  int            end_release = -1;
  int            xfer_col = 0;
  int            col_model = 0;
  int            xfers_done = 0;
  int            starts_total = 0;
  int            ovr_seen = 0;
  logic [25:0]   exp_frames[$];
  int            exp_pix[$];
  logic [25:0]   last_frame = '0;
  bit            exp_tick_start = 0;
  bit            exp_cap_start = 0;
  bit            chk_col = 0;
  bit            prev_req = 0;
  int            req_wait = 0;
  bit            rand_busy = 0;
  bit            rand_pix = 0;
  int            busy_fix = 10;

  // Monitor and scoreboard, sampled on the falling edge
  always @(negedge dostring_clk) begin
    logic        tick_now;
    logic [25:0] cur;
    logic [25:0] fe;
    int          b;
    if (dostring_reset) begin
      active = 0; end_release = -1; col_model = 0; req_wait = 0;
      exp_frames.delete(); exp_pix.delete();
      exp_tick_start = 0; exp_cap_start = 0; chk_col = 0; prev_req = 0;
    end else begin
      cyc++;
      tick_now = enable && ((en_run % CP) == CP - 1);
      cur = frame(bus.led_type, bus.led_blue, bus.led_green, bus.led_red);

      check("frame_overrun", frame_overrun, tick_now && active);
      if (frame_overrun) ovr_seen++;

      if (exp_tick_start) check("tick_to_start", {bus.led_start, bus.led_type}, {1'b1, INPUT_TYPE_START});
      if (exp_cap_start)  check("capture_to_start", {bus.led_start, bus.pix_req}, 2'b10);
      exp_tick_start = 0;
      exp_cap_start  = 0;
      if (chk_col) begin
        check("col_after_end", col_index, col_model);
        chk_col = 0;
      end

      if (bus.led_start) begin
        starts_total++;
        check("start_while_busy", bus.led_busy, 0);
        check("start_expected", bus.led_start, exp_frames.size() != 0);
        b = rand_busy ? int'($urandom_range(0, 12)) : busy_fix;
        next_busy = b;
        if (exp_frames.size() != 0) begin
          fe = exp_frames.pop_front();
          check("frame", cur, fe);
          if (fe[25:24] == INPUT_TYPE_END) end_release = cyc + ((b > 0) ? b : 1) + 1;
        end
        last_frame = cur;
      end else if (bus.led_busy) begin
        check("frame_hold", cur, last_frame);
      end

      if (bus.pix_req) begin
        if (!prev_req) begin
          check("pix_req_expected", bus.pix_req, exp_pix.size() != 0);
          if (exp_pix.size() != 0) check("pix_led_index", bus.pix_led_index, exp_pix.pop_front());
          check("pix_col_index", bus.pix_col_index, xfer_col);
          req_wait = 0;
        end
        if (!bus.pix_valid) begin
          req_wait++;
        end else begin
          check("pix_wait", req_wait, lat_cur);
          exp_cap_start = 1;
          if (rand_pix) pix_lat_next = $urandom_range(0, 6);
        end
      end
      prev_req = bus.pix_req;

      if (tick_now && !active) begin
        check("col_at_tick", col_index, col_model);
        active = 1;
        xfer_col = col_model;
        end_release = -1;
        exp_frames.push_back(frame(INPUT_TYPE_START, 8'd0, 8'd0, 8'd0));
        for (int n = 0; n < SS; n++) begin
          exp_frames.push_back(frame(INPUT_TYPE_LED, 8'(n), 8'(xfer_col), 8'h55));
          exp_pix.push_back(n);
        end
        exp_frames.push_back(frame(INPUT_TYPE_END, 8'd0, 8'd0, 8'd0));
        exp_tick_start = 1;
      end

      if (active && cyc == end_release) begin
        active = 0;
        col_model = (col_model + 1) % NS;
        xfers_done++;
        chk_col = 1;
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_led_start"}, bus.led_start, 0);
    check({tag, "_led_type"}, bus.led_type, 0);
    check({tag, "_led_rgb"}, {bus.led_blue, bus.led_green, bus.led_red}, 0);
    check({tag, "_pix_req"}, bus.pix_req, 0);
    check({tag, "_pix_idx"}, {bus.pix_led_index, bus.pix_col_index}, 0);
    check({tag, "_overrun"}, frame_overrun, 0);
    check({tag, "_col_index"}, col_index, 0);
  endtask

  task automatic wait_xfers(input int count, input int budget, input string tag);
    int target;
    int k;
    target = xfers_done + count;
    k = 0;
    while (xfers_done < target && k < budget) begin
      @(negedge dostring_clk);
      k++;
    end
    if (xfers_done < target) check({tag, "_timeout"}, xfers_done, target);
  endtask

  initial begin
    int k;
    int ovr0;
    int done0;
    int s0;

    // Reset state
    repeat (3) @(negedge dostring_clk);
    check_idle_outputs("reset");
    #2 dostring_reset = 1'b0;

    // Busy 10, instant pixels: four transfers walk columns 0,1,2,0
    busy_fix = 10; pix_lat_next = 0;
    enable = 1'b1;
    wait_xfers(4, 2000, "basic");

    // Pixel latency 5
    pix_lat_next = 5;
    wait_xfers(2, 800, "pix_delay");

    // Random doled busy and pixel latency
    rand_busy = 1; rand_pix = 1;
    wait_xfers(4, 1500, "random");
    rand_busy = 0; rand_pix = 0; pix_lat_next = 0;

    // Long doled busy: ticks arrive mid-transfer and are dropped
    busy_fix = 100;
    ovr0 = ovr_seen;
    wait_xfers(2, 3000, "overrun");
    check("overrun_seen", ovr_seen > ovr0, 1);
    busy_fix = 10;

    // Enable dropped in the middle of a transfer
    k = 0;
    while (!(active && exp_frames.size() <= 3) && k < 1000) begin
      @(negedge dostring_clk);
      k++;
    end
    check("reach_mid_transfer", active && exp_frames.size() <= 3, 1);
    #2 enable = 1'b0;
    done0 = xfers_done + 1;
    k = 0;
    while (active && k < 600) begin
      @(negedge dostring_clk);
      k++;
    end
    check("end_after_disable", xfers_done, done0);
    s0 = starts_total;
    repeat (600) @(negedge dostring_clk);
    check("no_start_disabled", starts_total, s0);
    check("frames_left", exp_frames.size(), 0);
    check("col_when_disabled", col_index, col_model);

    // Asynchronous reset during LED_WAIT
    enable = 1'b1;
    k = 0;
    while (!(bus.led_type == INPUT_TYPE_LED && bus.led_busy && !bus.led_start) && k < 1000) begin
      @(negedge dostring_clk);
      k++;
    end
    check("reach_led_wait", bus.led_type == INPUT_TYPE_LED && bus.led_busy, 1);
    @(negedge dostring_clk);
    #2 dostring_reset = 1'b1;
    #1 check_idle_outputs("async_reset");
    repeat (2) @(negedge dostring_clk);
    #2 dostring_reset = 1'b0;
    wait_xfers(2, 800, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
